// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath controls.
module multicycle_sequencer #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] instr,
  input  logic               EQ,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               ir_en,
  output logic               pc_en,
  output logic               PCsrc,
  output logic               RegWrite,
  output logic [2:0]         ALUctrl,
  output logic               ALUsrc,
  output logic [2:0]         ImmSrc,
  output logic               illegal,
  output logic [D_WIDTH-1:0] retired
);

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b111;
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  typedef enum logic [3:0] {
    C_ADDI, C_ADD, C_SUB, C_LW, C_SW, C_BEQ, C_BNE, C_JAL, C_ILL
  } class_e;

  state_e             state_q, state_d;
  class_e             class_q, class_d, dec_class;
  logic [D_WIDTH-1:0] ir_q, ir_d;
  logic               illegal_q, illegal_d;
  logic [D_WIDTH-1:0] retired_q, retired_d;
  logic               retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ir_unused;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign ir_unused = ^{ir_q[24:15], ir_q[11:7]};

  // Classification always looks at the latched IR, never the live instr bus.
  always_comb begin
    dec_class = C_ILL;
    case (opcode)
      7'h13: if (funct3 == 3'b000) dec_class = C_ADDI;
      7'h33: begin
        if (funct3 == 3'b000 && funct7 == 7'h00) dec_class = C_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'h20) dec_class = C_SUB;
      end
      7'h03: if (funct3 == 3'b010) dec_class = C_LW;
      7'h23: if (funct3 == 3'b010) dec_class = C_SW;
      7'h63: begin
        if (funct3 == 3'b000) dec_class = C_BEQ;
        else if (funct3 == 3'b001) dec_class = C_BNE;
      end
      7'h6F: dec_class = C_JAL;
      default: dec_class = C_ILL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    class_d   = class_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = ALU_PASS;
    ALUsrc    = 1'b1;
    ImmSrc    = IMM_NONE;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en   = 1'b1;
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        class_d = dec_class;
        if (dec_class == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (class_q)
          C_ADDI: begin
            ALUctrl = ALU_ADD;
            ImmSrc  = IMM_I;
            state_d = WB;
          end
          C_ADD: begin
            ALUctrl = ALU_ADD;
            ALUsrc  = 1'b0;
            state_d = WB;
          end
          C_SUB: begin
            ALUctrl = ALU_SUB;
            ALUsrc  = 1'b0;
            state_d = WB;
          end
          C_LW: begin
            ALUctrl = ALU_ADD;
            ImmSrc  = IMM_I;
            state_d = MEM;
          end
          C_SW: begin
            ALUctrl = ALU_ADD;
            ImmSrc  = IMM_S;
            state_d = MEM;
          end
          // Branch outcome uses the live EQ flag from the datapath compare.
          C_BEQ, C_BNE: begin
            ALUctrl = ALU_SUB;
            ALUsrc  = 1'b0;
            ImmSrc  = IMM_B;
            pc_en   = 1'b1;
            PCsrc   = (class_q == C_BEQ) ? EQ : !EQ;
            retire  = 1'b1;
            state_d = FETCH;
          end
          C_JAL: begin
            ImmSrc   = IMM_J;
            RegWrite = 1'b1;
            pc_en    = 1'b1;
            PCsrc    = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == C_SW);
        if (dmem_ack) begin
          if (class_q == C_SW) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase

    // An instruction interrupted by reset must leave no architectural trace.
    if (rst) begin
      RegWrite = 1'b0;
      pc_en    = 1'b0;
      ir_en    = 1'b0;
      retire   = 1'b0;
    end

    retired_d = retired_q + D_WIDTH'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      class_q   <= C_ILL;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: scoreboarded instruction
// runs with variable ack latency, plus reset, illegal-halt and wrap cases.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        eq_in = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, PCsrc, RegWrite;
  logic        ALUsrc, illegal;
  logic [2:0]  ALUctrl, ImmSrc;
  logic [31:0] retired;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_retired = '0;

  typedef struct {
    int         cycles;
    int         ir_cycle;
    int         regw;
    int         pcen;
    logic       pcsrc;
    int         dmem_cycles;
    logic       dmem_we;
    logic [2:0] alu;
    logic       src;
    logic [2:0] imm;
  } obs_t;

  obs_t exp_q[$];

  multicycle_sequencer #(.D_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .EQ(eq_in),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_en(ir_en), .pc_en(pc_en), .PCsrc(PCsrc), .RegWrite(RegWrite),
    .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Expected per-instruction behaviour; iw/dw are wait cycles before each ack.
  function automatic obs_t exp_model(input logic [31:0] w, input int iw, input int dw,
                                     input logic eq);
    obs_t e;
    e.cycles = -1; e.ir_cycle = iw + 1; e.regw = 0; e.pcen = 1; e.pcsrc = 1'b0;
    e.dmem_cycles = 0; e.dmem_we = 1'b0; e.alu = 3'b111; e.src = 1'b1; e.imm = 3'b111;
    case (w[6:0])
      7'h13: begin e.cycles = 4 + iw; e.regw = 1; e.alu = 3'b000; e.imm = 3'b000; end
      7'h33: begin e.cycles = 4 + iw; e.regw = 1; e.alu = w[30] ? 3'b001 : 3'b000; e.src = 1'b0; end
      7'h03: begin e.cycles = 5 + iw + dw; e.regw = 1; e.dmem_cycles = dw + 1; e.alu = 3'b000; e.imm = 3'b000; end
      7'h23: begin e.cycles = 4 + iw + dw; e.dmem_cycles = dw + 1; e.dmem_we = 1'b1; e.alu = 3'b000; e.imm = 3'b001; end
      7'h63: begin e.cycles = 3 + iw; e.pcsrc = w[12] ? !eq : eq; e.alu = 3'b001; e.src = 1'b0; e.imm = 3'b011; end
      7'h6F: begin e.cycles = 3 + iw; e.regw = 1; e.pcsrc = 1'b1; e.imm = 3'b100; end
      default: e.cycles = -1;
    endcase
    return e;
  endfunction

  // Plays the memory side for one instruction and records what the DUT did.
  task automatic run_instr(input logic [31:0] word, input int iw, input int dw,
                           input logic eq, input bit spurious, output obs_t o);
    int c = 0;
    int iseen = 0;
    int dseen = 0;
    bit done = 0;
    o.cycles = -1; o.ir_cycle = -1; o.regw = 0; o.pcen = 0; o.pcsrc = 1'b0;
    o.dmem_cycles = 0; o.dmem_we = 1'b0; o.alu = 3'bxxx; o.src = 1'bx; o.imm = 3'bxxx;
    while (!done && c < 60) begin
      c++;
      eq_in    = eq;
      imem_ack = imem_req && (iseen == iw);
      dmem_ack = dmem_req && (dseen == dw);
      if (spurious) begin
        if (imem_req && !imem_ack) dmem_ack = 1'b1;
        if (dmem_req && !dmem_ack) imem_ack = 1'b1;
        if (!imem_req && !dmem_req) begin imem_ack = 1'b1; dmem_ack = 1'b1; end
      end
      instr = (imem_ack && imem_req) ? word : $urandom();
      #1;
      if (imem_req) iseen++;
      if (dmem_req) begin
        dseen++;
        o.dmem_cycles++;
        if (dmem_we) o.dmem_we = 1'b1;
      end
      if (ir_en) o.ir_cycle = c;
      if (RegWrite) o.regw++;
      if (c == iw + 3) begin o.alu = ALUctrl; o.src = ALUsrc; o.imm = ImmSrc; end
      if (pc_en) begin o.pcen++; o.pcsrc = PCsrc; o.cycles = c; done = 1; end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (!done) begin
      errors++;
      $display("[TB] FAIL timeout word=%08h got=no pc_en exp=pc_en within 60 cycles", word);
    end
    checks++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_imem_req got=%b exp=1", imem_req); end
    checks++; if ({dmem_req, dmem_we, ir_en, pc_en, PCsrc, RegWrite} !== 6'b0) begin errors++; $display("[TB] FAIL rst_strobes got=%b exp=000000", {dmem_req, dmem_we, ir_en, pc_en, PCsrc, RegWrite}); end
    checks++; if ({ALUctrl, ALUsrc, ImmSrc} !== 7'b111_1_111) begin errors++; $display("[TB] FAIL rst_ctrl got=%b exp=1111111", {ALUctrl, ALUsrc, ImmSrc}); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL rst_illegal got=%b exp=0", illegal); end
    checks++; if (retired !== 32'd0) begin errors++; $display("[TB] FAIL rst_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_alu();
    logic [31:0] words[3] = '{32'h00500093, 32'h002081B3, 32'h402081B3};
    obs_t g, e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_model(words[i], i, 0, 1'b0));
      run_instr(words[i], i, 0, 1'b0, 1'b0, g);
      exp_retired++;
      e = exp_q.pop_front();
      checks++; if (g.cycles !== e.cycles) begin errors++; $display("[TB] FAIL alu%0d_cycles got=%0d exp=%0d", i, g.cycles, e.cycles); end
      checks++; if (g.ir_cycle !== e.ir_cycle) begin errors++; $display("[TB] FAIL alu%0d_ir_en got=%0d exp=%0d", i, g.ir_cycle, e.ir_cycle); end
      checks++; if (g.regw !== e.regw) begin errors++; $display("[TB] FAIL alu%0d_regwrite got=%0d exp=%0d", i, g.regw, e.regw); end
      checks++; if ({g.alu, g.src, g.imm} !== {e.alu, e.src, e.imm}) begin errors++; $display("[TB] FAIL alu%0d_exec_ctrl got=%b exp=%b", i, {g.alu, g.src, g.imm}, {e.alu, e.src, e.imm}); end
      checks++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL alu%0d_retired got=%0d exp=%0d", i, retired, exp_retired); end
    end
  endtask

  task automatic test_load_store();
    logic [31:0] words[3] = '{32'h0000A103, 32'h0020A023, 32'h0020A023};
    int iws[3] = '{2, 0, 1};
    int dws[3] = '{2, 0, 2};
    obs_t g, e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_model(words[i], iws[i], dws[i], 1'b0));
      run_instr(words[i], iws[i], dws[i], 1'b0, i == 2, g);
      exp_retired++;
      e = exp_q.pop_front();
      checks++; if (g.cycles !== e.cycles) begin errors++; $display("[TB] FAIL ls%0d_cycles got=%0d exp=%0d", i, g.cycles, e.cycles); end
      checks++; if (g.dmem_cycles !== e.dmem_cycles) begin errors++; $display("[TB] FAIL ls%0d_dmem_req_cycles got=%0d exp=%0d", i, g.dmem_cycles, e.dmem_cycles); end
      checks++; if (g.dmem_we !== e.dmem_we) begin errors++; $display("[TB] FAIL ls%0d_dmem_we got=%b exp=%b", i, g.dmem_we, e.dmem_we); end
      checks++; if (g.regw !== e.regw) begin errors++; $display("[TB] FAIL ls%0d_regwrite got=%0d exp=%0d", i, g.regw, e.regw); end
      checks++; if ({g.alu, g.src, g.imm} !== {e.alu, e.src, e.imm}) begin errors++; $display("[TB] FAIL ls%0d_exec_ctrl got=%b exp=%b", i, {g.alu, g.src, g.imm}, {e.alu, e.src, e.imm}); end
      checks++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL ls%0d_retired got=%0d exp=%0d", i, retired, exp_retired); end
    end
  endtask

  task automatic test_branch_jal();
    logic [31:0] words[5] = '{32'hFE209EE3, 32'hFE209EE3, 32'h00208463, 32'h00208463, 32'h008000EF};
    logic eqs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    obs_t g, e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exp_model(words[i], i % 2, 0, eqs[i]));
      run_instr(words[i], i % 2, 0, eqs[i], 1'b0, g);
      exp_retired++;
      e = exp_q.pop_front();
      checks++; if (g.cycles !== e.cycles) begin errors++; $display("[TB] FAIL br%0d_cycles got=%0d exp=%0d", i, g.cycles, e.cycles); end
      checks++; if (g.pcsrc !== e.pcsrc) begin errors++; $display("[TB] FAIL br%0d_pcsrc got=%b exp=%b", i, g.pcsrc, e.pcsrc); end
      checks++; if (g.regw !== e.regw) begin errors++; $display("[TB] FAIL br%0d_regwrite got=%0d exp=%0d", i, g.regw, e.regw); end
      checks++; if ({g.alu, g.src, g.imm} !== {e.alu, e.src, e.imm}) begin errors++; $display("[TB] FAIL br%0d_exec_ctrl got=%b exp=%b", i, {g.alu, g.src, g.imm}, {e.alu, e.src, e.imm}); end
      checks++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL br%0d_retired got=%0d exp=%0d", i, retired, exp_retired); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[8] = '{32'h00500093, 32'h002081B3, 32'h402081B3, 32'h0000A103,
                              32'h0020A023, 32'h00208463, 32'hFE209EE3, 32'h008000EF};
    int iw, dw;
    logic eq;
    obs_t g, e;
    for (int i = 0; i < 16; i++) begin
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      eq = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_model(words[i % 8], iw, dw, eq));
      run_instr(words[i % 8], iw, dw, eq, i[0], g);
      exp_retired++;
      e = exp_q.pop_front();
      checks++; if (g.cycles !== e.cycles) begin errors++; $display("[TB] FAIL b2b%0d_cycles got=%0d exp=%0d", i, g.cycles, e.cycles); end
      checks++; if (g.ir_cycle !== e.ir_cycle) begin errors++; $display("[TB] FAIL b2b%0d_ir_en got=%0d exp=%0d", i, g.ir_cycle, e.ir_cycle); end
      checks++; if (g.regw !== e.regw || g.pcen !== e.pcen) begin errors++; $display("[TB] FAIL b2b%0d_strobes got=%0d/%0d exp=%0d/%0d", i, g.regw, g.pcen, e.regw, e.pcen); end
      checks++; if (g.pcsrc !== e.pcsrc) begin errors++; $display("[TB] FAIL b2b%0d_pcsrc got=%b exp=%b", i, g.pcsrc, e.pcsrc); end
      checks++; if (g.dmem_cycles !== e.dmem_cycles || g.dmem_we !== e.dmem_we) begin errors++; $display("[TB] FAIL b2b%0d_dmem got=%0d/%b exp=%0d/%b", i, g.dmem_cycles, g.dmem_we, e.dmem_cycles, e.dmem_we); end
      checks++; if ({g.alu, g.src, g.imm} !== {e.alu, e.src, e.imm}) begin errors++; $display("[TB] FAIL b2b%0d_exec_ctrl got=%b exp=%b", i, {g.alu, g.src, g.imm}, {e.alu, e.src, e.imm}); end
      checks++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL b2b%0d_retired got=%0d exp=%0d", i, retired, exp_retired); end
    end
  endtask

  task automatic test_wrap();
    obs_t g, e;
    do_reset();
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    #1;
    exp_retired = 32'hFFFF_FFFF;
    checks++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL wrap_preload got=%08h exp=%08h", retired, exp_retired); end
    exp_q.push_back(exp_model(32'h00500093, 0, 0, 1'b0));
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, g);
    exp_retired++;
    e = exp_q.pop_front();
    checks++; if (g.cycles !== e.cycles) begin errors++; $display("[TB] FAIL wrap_cycles got=%0d exp=%0d", g.cycles, e.cycles); end
    checks++; if (retired !== 32'd0) begin errors++; $display("[TB] FAIL wrap_retired got=%08h exp=00000000", retired); end
  endtask

  task automatic test_reset_mid_mem();
    obs_t g;
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, g);
    instr = 32'h0000A103; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; instr = $urandom();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL midmem_req got=%b exp=1", dmem_req); end
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0 || pc_en !== 1'b0) begin errors++; $display("[TB] FAIL midmem_abort_strobes got=%b%b exp=00", RegWrite, pc_en); end
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b0;
    exp_retired = '0;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL midmem_req_drop got=%b exp=0", dmem_req); end
    checks++; if (retired !== exp_retired) begin errors++; $display("[TB] FAIL midmem_retired got=%0d exp=0", retired); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL midmem_refetch got=%b exp=1", imem_req); end
  endtask

  task automatic test_illegal();
    logic [31:0] words[5] = '{32'hFFFFFFFF, 32'h00109093, 32'h00008103, 32'h022081B3, 32'h00209023};
    int busy;
    for (int k = 0; k < 5; k++) begin
      do_reset();
      instr = words[k]; imem_ack = 1'b1;
      #1;
      checks++; if (ir_en !== 1'b1) begin errors++; $display("[TB] FAIL ill%0d_ir_en got=%b exp=1", k, ir_en); end
      @(negedge clk);
      imem_ack = 1'b0; instr = $urandom();
      #1;
      checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL ill%0d_decode got=%b exp=0", k, illegal); end
      @(negedge clk);
      #1;
      checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL ill%0d_flag got=%b exp=1", k, illegal); end
      busy = 0;
      for (int i = 0; i < 20; i++) begin
        imem_ack = i[0]; dmem_ack = ~i[0];
        #1;
        busy += int'(imem_req) + int'(dmem_req) + int'(pc_en) + int'(RegWrite) + int'(ir_en);
        @(negedge clk);
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      checks++; if (busy !== 0) begin errors++; $display("[TB] FAIL ill%0d_halt_activity got=%0d exp=0", k, busy); end
      checks++; if (illegal !== 1'b1 || retired !== exp_retired) begin errors++; $display("[TB] FAIL ill%0d_sticky got=%b/%0d exp=1/%0d", k, illegal, retired, exp_retired); end
      do_reset();
      #1;
      checks++; if (illegal !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL ill%0d_recover got=%b/%b exp=0/1", k, illegal, imem_req); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jal();
    test_back_to_back();
    test_wrap();
    test_reset_mid_mem();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
